// File: rtl/final_sum_54_if.sv
// Operand/result handshake bundle between the partial-product adders, the
// final-sum stage and the product consumer.
interface final_sum_54_if #(
    parameter int RADIX = 54
);
    localparam int W = 2 * RADIX;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] res_0;
    logic [W-1:0] res_1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    modport master (
        output in_valid, res_0, res_1, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );

    modport slave (
        input  in_valid, res_0, res_1, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
endinterface

// File: rtl/final_sum_54.sv
// Multi-cycle final adder: sums two 2*RADIX-bit partial sums CHUNK bits per
// cycle through a registered carry, trading latency for a short carry chain.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a new operand pair (in_ready=1)
// ADD    | adding chunk idx, carry held in carry_q between chunks
// DONE   | result held on sum/carry_out until out_ready (out_valid=1)
module final_sum_54 #(
    parameter int RADIX = 54,
    parameter int CHUNK = 27
) (
    input  logic            clk,
    input  logic            rst_n,
    final_sum_54_if.slave   bus
);
    localparam int W      = 2 * RADIX;
    localparam int NCHUNK = W / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (W % CHUNK != 0) begin : g_chunk_check
            $error("final_sum_54: CHUNK must divide 2*RADIX");
        end
    endgenerate

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    op0_q, op0_d;
    logic [W-1:0]    op1_q, op1_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            carry_out_q, carry_out_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [CHUNK-1:0] a_w;
    logic [CHUNK-1:0] b_w;
    logic [CHUNK:0]   add_w;

    always_comb begin
        state_d     = state_q;
        op0_d       = op0_q;
        op1_d       = op1_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        idx_d       = idx_q;
        a_w         = '0;
        b_w         = '0;

        // Constant-offset mux keeps the chunk select free of variable part-selects.
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_w = op0_q[i*CHUNK +: CHUNK];
                b_w = op1_q[i*CHUNK +: CHUNK];
            end
        end
        add_w = {1'b0, a_w} + {1'b0, b_w} + (CHUNK+1)'(carry_q);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op0_d   = bus.res_0;
                    op1_d   = bus.res_1;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = add_w[CHUNK-1:0];
                    end
                end
                carry_d = add_w[CHUNK];
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    carry_out_d = add_w[CHUNK];
                    idx_d       = '0;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op0_q       <= '0;
            op1_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_final_sum_54.sv
// Directed and random checks of the chunked final adder: latency, carry
// ripple across chunks, backpressure, reset abort and in-order results.
module tb_final_sum_54;
    localparam int W = 108;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    final_sum_54_if #(.RADIX(54)) bus ();

    final_sum_54 #(.RADIX(54), .CHUNK(27)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one pair with out_ready=1 and checks latency and result.
    task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] es, input logic ec);
        int lat;
        bus.in_valid  = 1'b1;
        bus.res_0     = a;
        bus.res_1     = b;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.res_0    = '0;
        bus.res_1    = '0;
        chk({tag, "_busy"}, bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_carry"}, bus.carry_out, ec);
        tick();
        chk({tag, "_valid_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        int          lat;
        bit          seen;
        int          results;
        int          cyc;
        int          last;
        int          mode;
        bit          acc;
        bit          ret;
        logic [127:0] t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   e;
        logic [W:0]   exp_q[$];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.res_0     = '0;
        bus.res_1     = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_carry", bus.carry_out, 0);

        run_txn("basic", 108'd1, 108'd2, 108'd3, 1'b0);
        run_txn("chunk_cross", {81'd0, {27{1'b1}}}, 108'd1, 108'h800_0000, 1'b0);
        run_txn("full_ripple", {108{1'b1}}, 108'd1, 108'd0, 1'b1);
        run_txn("half_ones", 108'h3F_FFFF_FFFF_FFFF, 108'h3F_FFFF_FFFF_FFFF,
                108'h7F_FFFF_FFFF_FFFE, 1'b0);
        run_txn("top_bit", {1'b1, 107'd0}, {1'b1, 107'd0}, 108'd0, 1'b1);
        run_txn("bit28", 108'hFFF_FFFF, 108'd1, 108'h1000_0000, 1'b0);

        // Backpressure with in_valid/operand churn while the result is held.
        bus.in_valid  = 1'b1;
        bus.res_0     = 108'h123;
        bus.res_1     = 108'h456;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.res_0    = W'($urandom);
            bus.res_1    = W'($urandom);
            tick();
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_sum", bus.sum, 108'h579);
            chk("bp_carry", bus.carry_out, 0);
        end
        // in_valid and out_ready together in DONE: only the result handshake.
        bus.in_valid  = 1'b1;
        bus.res_0     = 108'd10;
        bus.res_1     = 108'd20;
        bus.out_ready = 1'b1;
        tick();
        chk("dual_out_valid", bus.out_valid, 0);
        chk("dual_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("dual_accepted", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("dual_latency", lat, 4);
        chk("dual_sum", bus.sum, 108'd30);
        tick();

        // Reset two cycles into ADD, asserted between clock edges.
        bus.in_valid = 1'b1;
        bus.res_0    = 108'hFFFF;
        bus.res_1    = 108'd1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_sum", bus.sum, 0);
        chk("arst_carry", bus.carry_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("arst_no_result", seen, 0);
        run_txn("post_reset", 108'd5, 108'd7, 108'd12, 1'b0);

        // Random stalls; results must come back in order and at least 6 apart.
        results = 0;
        cyc     = 0;
        last    = -100;
        while (results < 1000 && cyc < 60000) begin
            t  = {$urandom, $urandom, $urandom, $urandom};
            ra = t[W-1:0];
            t  = {$urandom, $urandom, $urandom, $urandom};
            rb = t[W-1:0];
            mode = $urandom_range(0, 3);
            if (mode == 1) rb = ~ra;
            if (mode == 2) rb = ~ra + 1'b1;
            bus.res_0     = ra;
            bus.res_1     = rb;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            acc = bus.in_valid && bus.in_ready;
            ret = bus.out_valid && bus.out_ready;
            if (ret) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_result", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_result", {bus.carry_out, bus.sum}, e);
                end
                if (results > 0) chk("rnd_spacing", (cyc - last) >= 6, 1);
                last = cyc;
                results++;
            end
            if (acc) exp_q.push_back({1'b0, ra} + {1'b0, rb});
            tick();
            cyc++;
        end
        chk("rnd_result_count", results, 1000);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
